// File: rtl/map_table_pkg.sv
// Shared types and sizing for the superscalar register-renaming map table.
// Widths are fixed here so every file agrees on the packed layouts.
package map_table_pkg;

  localparam int NUM_REGS = 32;
  localparam int TAG_W    = 5;
  localparam int WAYS     = 2;
  localparam int AREG_W   = $clog2(NUM_REGS);

  localparam logic [TAG_W-1:0] INVALID_TAG = {TAG_W{1'b1}};

  typedef enum logic [1:0] {
    IN_RF   = 2'b00,
    PENDING = 2'b10,
    READY   = 2'b11
  } DATA_STAT;

  typedef struct packed {
    logic [TAG_W-1:0] rob_tag;
    logic             ready;
  } MT_ENTRY;

  typedef struct packed {
    DATA_STAT          data_stat;
    logic [AREG_W-1:0] reg_addr;
    logic [TAG_W-1:0]  rob_tag;
  } SRC_T;

  localparam MT_ENTRY EMPTY_ENTRY = '{rob_tag: INVALID_TAG, ready: 1'b0};

endpackage

// File: rtl/map_table_ss_if.sv
// Dispatch / CDB / commit / flush bundle between the decoder side and the map table.
interface map_table_ss_if;
  import map_table_pkg::*;

  logic                               flush;
  logic [WAYS-1:0]                    disp_valid;
  logic [WAYS-1:0][AREG_W-1:0]        disp_src1;
  logic [WAYS-1:0][AREG_W-1:0]        disp_src2;
  logic [WAYS-1:0][AREG_W-1:0]        disp_dest;
  logic [WAYS-1:0][TAG_W-1:0]         disp_rob_tag;
  logic [WAYS-1:0]                    cdb_valid;
  logic [WAYS-1:0][TAG_W-1:0]         cdb_tag;
  logic [WAYS-1:0]                    cmt_valid;
  logic [WAYS-1:0][AREG_W-1:0]        cmt_dest;
  logic [WAYS-1:0][TAG_W-1:0]         cmt_tag;
  SRC_T [WAYS-1:0]                    ren_src1;
  SRC_T [WAYS-1:0]                    ren_src2;
  logic [WAYS-1:0][AREG_W-1:0]        ren_dest;
  logic [WAYS-1:0][TAG_W-1:0]         ren_rob_tag;
  logic [AREG_W:0]                    pending_cnt;

  modport master (
    output flush, disp_valid, disp_src1, disp_src2, disp_dest, disp_rob_tag,
           cdb_valid, cdb_tag, cmt_valid, cmt_dest, cmt_tag,
    input  ren_src1, ren_src2, ren_dest, ren_rob_tag, pending_cnt
  );

  modport slave (
    input  flush, disp_valid, disp_src1, disp_src2, disp_dest, disp_rob_tag,
           cdb_valid, cdb_tag, cmt_valid, cmt_dest, cmt_tag,
    output ren_src1, ren_src2, ren_dest, ren_rob_tag, pending_cnt
  );

endinterface

// File: rtl/mt_src_lookup.sv
// Single-source rename resolver: r0, intra-group forwarding, table state, CDB bypass.
module mt_src_lookup
  import map_table_pkg::*;
#(
  parameter int WAY = 0
) (
  input  logic [AREG_W-1:0]             src,
  input  MT_ENTRY                       entry,
  input  logic [WAYS-1:0]               disp_valid,
  input  logic [WAYS-1:0][AREG_W-1:0]   disp_dest,
  input  logic [WAYS-1:0][TAG_W-1:0]    disp_rob_tag,
  input  logic [WAYS-1:0]               cdb_valid,
  input  logic [WAYS-1:0][TAG_W-1:0]    cdb_tag,
  output SRC_T                          res
);

  logic             fwd_hit;
  logic [TAG_W-1:0] fwd_tag;
  logic             cdb_hit;

  always_comb begin
    // NOTE: every comb output gets a default before any branch, so no latch is inferred.
    fwd_hit = 1'b0;
    fwd_tag = INVALID_TAG;
    cdb_hit = 1'b0;
    // Ascending scan: the last (nearest older) producing way overrides earlier ones.
    for (int j = 0; j < WAYS; j++) begin
      if (j < WAY && disp_valid[j] && disp_dest[j] == src && disp_dest[j] != '0) begin
        fwd_hit = 1'b1;
        fwd_tag = disp_rob_tag[j];
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (cdb_valid[w] && cdb_tag[w] == entry.rob_tag) cdb_hit = 1'b1;
    end

    res = '{data_stat: IN_RF, reg_addr: src, rob_tag: INVALID_TAG};
    if (src == '0) begin
      res.data_stat = IN_RF;
    end else if (fwd_hit) begin
      res.data_stat = PENDING;
      res.rob_tag   = fwd_tag;
    end else if (entry.rob_tag == INVALID_TAG) begin
      res.data_stat = IN_RF;
    end else begin
      res.data_stat = (cdb_hit || entry.ready) ? READY : PENDING;
      res.rob_tag   = entry.rob_tag;
    end
  end

endmodule

// File: rtl/map_table_ss.sv
// Superscalar map table: WAYS-wide rename lookup, CDB wakeup, in-order commit clear, flush.
module map_table_ss
  import map_table_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  map_table_ss_if.slave        bus
);

  MT_ENTRY         tbl     [NUM_REGS];
  MT_ENTRY         tbl_nxt [NUM_REGS];
  logic [AREG_W:0] cnt_nxt;

  for (genvar k = 0; k < WAYS; k++) begin : g_way
    mt_src_lookup #(.WAY(k)) u_src1 (
      .src          (bus.disp_src1[k]),
      .entry        (tbl[bus.disp_src1[k]]),
      .disp_valid   (bus.disp_valid),
      .disp_dest    (bus.disp_dest),
      .disp_rob_tag (bus.disp_rob_tag),
      .cdb_valid    (bus.cdb_valid),
      .cdb_tag      (bus.cdb_tag),
      .res          (bus.ren_src1[k])
    );
    mt_src_lookup #(.WAY(k)) u_src2 (
      .src          (bus.disp_src2[k]),
      .entry        (tbl[bus.disp_src2[k]]),
      .disp_valid   (bus.disp_valid),
      .disp_dest    (bus.disp_dest),
      .disp_rob_tag (bus.disp_rob_tag),
      .cdb_valid    (bus.cdb_valid),
      .cdb_tag      (bus.cdb_tag),
      .res          (bus.ren_src2[k])
    );
  end

  assign bus.ren_dest    = bus.disp_dest;
  assign bus.ren_rob_tag = bus.disp_rob_tag;

  // Passes are ordered lowest to highest priority so later writes win.
  always_comb begin
    // NOTE: blocking assignments here build the next state step by step; registers use <=.
    tbl_nxt = tbl;
    for (int i = 1; i < NUM_REGS; i++) begin
      for (int w = 0; w < WAYS; w++) begin
        if (bus.cdb_valid[w] && tbl[i].rob_tag != INVALID_TAG && bus.cdb_tag[w] == tbl[i].rob_tag)
          tbl_nxt[i].ready = 1'b1;
      end
    end
    // A tag mismatch means the register was renamed again; leave it alone.
    for (int w = 0; w < WAYS; w++) begin
      if (bus.cmt_valid[w] && bus.cmt_dest[w] != '0 &&
          tbl[bus.cmt_dest[w]].rob_tag == bus.cmt_tag[w])
        tbl_nxt[bus.cmt_dest[w]] = EMPTY_ENTRY;
    end
    for (int w = 0; w < WAYS; w++) begin
      if (bus.disp_valid[w] && bus.disp_dest[w] != '0)
        tbl_nxt[bus.disp_dest[w]] = '{rob_tag: bus.disp_rob_tag[w], ready: 1'b0};
    end
    if (bus.flush) begin
      for (int i = 0; i < NUM_REGS; i++) tbl_nxt[i] = EMPTY_ENTRY;
    end

    cnt_nxt = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (tbl_nxt[i].rob_tag != INVALID_TAG) cnt_nxt = cnt_nxt + {{AREG_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the table is reset like ordinary flops because "not renamed" must hold after reset.
      for (int i = 0; i < NUM_REGS; i++) tbl[i] <= EMPTY_ENTRY;
      bus.pending_cnt <= '0;
    end else begin
      tbl             <= tbl_nxt;
      bus.pending_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_map_table_ss.sv
// Directed bench for map_table_ss: stimulus pushes expected lookups into a scoreboard,
// a negedge monitor pops and compares them against the DUT outputs of that cycle.
module tb_map_table_ss;
  import map_table_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  map_table_ss_if bus ();

  map_table_ss dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // sel: 0/1 = src1/src2 of way0, 2/3 = src1/src2 of way1, 4 = pending_cnt
  typedef struct {
    int          cyc;
    int          sel;
    logic [11:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];

  function automatic logic [11:0] pick(int sel);
    case (sel)
      0:       return bus.ren_src1[0];
      1:       return bus.ren_src2[0];
      2:       return bus.ren_src1[1];
      3:       return bus.ren_src2[1];
      default: return {5'd0, bus.pending_cnt[5:0], 1'b0} >> 1;
    endcase
  endfunction

  task automatic exp_src(string name, int sel, logic [1:0] st, int r, int tag);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.name = name;
    e.val = {st, 5'(r), 5'(tag)};
    sb.push_back(e);
  endtask

  task automatic exp_cnt(string name, int n);
    exp_t e;
    e.cyc = cyc; e.sel = 4; e.name = name;
    e.val = 12'(n);
    sb.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    reset            = 1'b0;
    bus.flush        = 1'b0;
    bus.disp_valid   = '0;
    bus.disp_src1    = '0;
    bus.disp_src2    = '0;
    bus.disp_dest    = '0;
    bus.disp_rob_tag = '0;
    bus.cdb_valid    = '0;
    bus.cdb_tag      = '0;
    bus.cmt_valid    = '0;
    bus.cmt_dest     = '0;
    bus.cmt_tag      = '0;
  endtask

  task automatic disp(int w, int s1, int s2, int d, int tag);
    bus.disp_valid[w]   = 1'b1;
    bus.disp_src1[w]    = 5'(s1);
    bus.disp_src2[w]    = 5'(s2);
    bus.disp_dest[w]    = 5'(d);
    bus.disp_rob_tag[w] = 5'(tag);
  endtask

  task automatic cdb(int w, int tag);
    bus.cdb_valid[w] = 1'b1;
    bus.cdb_tag[w]   = 5'(tag);
  endtask

  task automatic cmt(int w, int d, int tag);
    bus.cmt_valid[w] = 1'b1;
    bus.cmt_dest[w]  = 5'(d);
    bus.cmt_tag[w]   = 5'(tag);
  endtask

  task automatic check(string name, logic [11:0] act, logic [11:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares every expectation tagged for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL %s: stale expectation from cycle %0d seen at %0d", e.name, e.cyc, cyc);
      end else begin
        check(e.name, pick(e.sel), e.val);
      end
    end
  end

  localparam logic [1:0] S_RF = 2'b00, S_PD = 2'b10, S_RD = 2'b11;

  initial begin
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b1;
    next_cycle();

    // Empty table; dispatch to r0 must not rename it.
    disp(0, 5, 0, 0, 7);
    disp(1, 0, 5, 9, 8);
    bus.disp_valid[1] = 1'b1;
    bus.disp_dest[1]  = 5'd0;
    exp_src("reset_r5", 0, S_RF, 5, 31);
    exp_src("reset_r0", 1, S_RF, 0, 31);
    exp_src("r0_after_r0_dest", 2, S_RF, 0, 31);
    exp_cnt("reset_cnt", 0);
    next_cycle();

    // Intra-group forwarding r3 <- tag 4.
    disp(0, 1, 2, 3, 4);
    disp(1, 3, 0, 0, 5);
    exp_src("empty_r1", 0, S_RF, 1, 31);
    exp_src("fwd_r3", 2, S_PD, 3, 4);
    exp_src("src_r0", 3, S_RF, 0, 31);
    exp_cnt("cnt_r0_dest", 0);
    next_cycle();

    disp(0, 3, 0, 0, 0);
    exp_src("table_r3", 0, S_PD, 3, 4);
    exp_cnt("cnt_one", 1);
    next_cycle();

    // CDB bypass on port 1.
    disp(0, 3, 0, 0, 0);
    cdb(1, 4);
    exp_src("cdb_bypass", 0, S_RD, 3, 4);
    next_cycle();

    disp(0, 3, 0, 0, 0);
    exp_src("table_ready", 0, S_RD, 3, 4);
    exp_cnt("cnt_ready", 1);
    next_cycle();

    // Commit and dispatch on r3 in the same cycle: dispatch wins.
    disp(0, 3, 0, 3, 9);
    disp(1, 3, 0, 0, 0);
    cmt(0, 3, 4);
    exp_src("pre_commit_r3", 0, S_RD, 3, 4);
    exp_src("fwd_new_r3", 2, S_PD, 3, 9);
    next_cycle();

    disp(0, 3, 0, 0, 0);
    cmt(1, 3, 4);
    exp_src("disp_beats_cmt", 0, S_PD, 3, 9);
    exp_cnt("cnt_after_cmt", 1);
    next_cycle();

    // Stale commit ignored; then CDB and commit on r3 together: commit wins.
    disp(0, 3, 0, 0, 0);
    cdb(0, 9);
    cmt(0, 3, 9);
    exp_src("stale_cmt_kept", 0, S_RD, 3, 9);
    next_cycle();

    // Both ways rename r7; way1 reads r7 forwarded from way0.
    disp(0, 3, 0, 7, 2);
    disp(1, 0, 7, 7, 6);
    exp_src("cmt_beats_cdb", 0, S_RF, 3, 31);
    exp_src("fwd_r7_way0", 3, S_PD, 7, 2);
    exp_cnt("cnt_empty", 0);
    next_cycle();

    disp(0, 7, 0, 1, 10);
    disp(1, 0, 0, 2, 11);
    exp_src("r7_high_way", 0, S_PD, 7, 6);
    exp_cnt("cnt_r7", 1);
    next_cycle();

    disp(0, 1, 2, 4, 12);
    exp_src("r1_tag10", 0, S_PD, 1, 10);
    exp_src("r2_tag11", 1, S_PD, 2, 11);
    exp_cnt("cnt_three", 3);
    next_cycle();

    // Flush with a dispatch to r8: lookups still see pre-flush state.
    bus.flush = 1'b1;
    disp(0, 4, 7, 8, 13);
    disp(1, 1, 0, 0, 0);
    exp_src("flush_r4", 0, S_PD, 4, 12);
    exp_src("flush_r7", 1, S_PD, 7, 6);
    exp_src("flush_r1", 2, S_PD, 1, 10);
    exp_cnt("cnt_four", 4);
    next_cycle();

    disp(0, 8, 4, 5, 3);
    disp(1, 7, 1, 0, 0);
    exp_src("post_flush_r8", 0, S_RF, 8, 31);
    exp_src("post_flush_r4", 1, S_RF, 4, 31);
    exp_src("post_flush_r7", 2, S_RF, 7, 31);
    exp_src("post_flush_r1", 3, S_RF, 1, 31);
    exp_cnt("cnt_flush", 0);
    next_cycle();

    // Mid-operation reset.
    reset = 1'b1;
    disp(0, 5, 0, 0, 0);
    exp_src("pre_reset_r5", 0, S_PD, 5, 3);
    exp_cnt("cnt_pre_reset", 1);
    next_cycle();

    disp(0, 5, 0, 0, 0);
    exp_src("post_reset_r5", 0, S_RF, 5, 31);
    exp_cnt("cnt_post_reset", 0);
    next_cycle();

    for (int i = 0; i < 10 && sb.size() > 0; i++) next_cycle();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
